// File: rtl/synth_pkg.sv
// Shared constants and types for the PS/2 keyboard synth voice allocator.
package synth_pkg;

    localparam int NOTE_W = 7;
    localparam int VOL_W  = 4;
    localparam logic [VOL_W-1:0] VOL_MAX = 4'd15;

    // Key map: KEY_CODES[k] plays MIDI note KEY_NOTE_BASE + k (one chromatic octave C3..C4).
    localparam int KEY_MAP_N     = 13;
    localparam int KEY_NOTE_BASE = 48;
    localparam logic [7:0] KEY_CODES [KEY_MAP_N] = '{
        8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A,
        8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A, 8'h41
    };

    // Decoded key event travelling from stage 1 to stage 2.
    typedef struct packed {
        logic              valid;
        logic              press;
        logic [NOTE_W-1:0] note;
    } note_evt_t;

    // How a stage-2 event chooses its voice.
    typedef enum logic [2:0] {
        SrcNone,
        SrcSame,
        SrcFree,
        SrcSteal,
        SrcDrop
    } alloc_src_t;

    function automatic logic [NOTE_W-1:0] key_note(input int unsigned idx);
        return NOTE_W'(KEY_NOTE_BASE + idx);
    endfunction

endpackage

// File: rtl/ps2_note_map.sv
// Set-2 scancode to MIDI note lookup; hit=0 for codes outside the key map.
module ps2_note_map
    import synth_pkg::*;
(
    input  logic [7:0]        i_scancode,
    output logic [NOTE_W-1:0] note,
    output logic              hit
);

    // Linear search of the key map; at most one entry can match.
    always_comb begin
        note = '0;
        hit  = 1'b0;
        for (int k = 0; k < KEY_MAP_N; k++) begin
            if (i_scancode == KEY_CODES[k]) begin
                note = key_note(k);
                hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_voice_alloc.sv
// Polyphonic voice allocator driven by PS/2 key events.
// Stage 0 detects a toggle on ps2_key[10], stage 1 holds the decoded note, stage 2 updates voices.
// Optional build macro: VOICE_STEAL_EN -- steal the oldest voice instead of dropping a note-on
// when every voice is sounding.
module ps2_voice_alloc
    import synth_pkg::*;
#(
    parameter int NUM_VOICES    = 4,
    parameter int RELEASE_TICKS = 9600
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [10:0]                  ps2_key,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES*VOL_W-1:0]  voice_volume,
    output logic                         event_drop
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int AGE_W = $clog2(NUM_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);
    localparam int PS_W = (RELEASE_TICKS > 1) ? $clog2(RELEASE_TICKS) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(RELEASE_TICKS - 1);

    // Stage 0/1 state
    logic      r_armed;
    logic      r_tog;
    note_evt_t r_s1;

    // Voice state
    logic [NOTE_W-1:0] r_note [NUM_VOICES];
    logic [VOL_W-1:0]  r_vol  [NUM_VOICES];
    logic [AGE_W-1:0]  r_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_gate;
    logic [PS_W-1:0]   r_ps;
    logic              r_drop;

    // Combinational signals
    logic              w_evt;
    logic [NOTE_W-1:0] w_map_note;
    logic              w_map_hit;
    note_evt_t         w_s1_d;
    logic              w_tick;
    logic              w_same_hit;
    logic [IDX_W-1:0]  w_same_idx;
    logic              w_free_hit;
    logic [IDX_W-1:0]  w_free_idx;
    logic [IDX_W-1:0]  w_old_idx;
    logic [AGE_W-1:0]  w_old_age;
    alloc_src_t        w_src;
    logic [IDX_W-1:0]  w_tgt;
    logic              w_place;
    logic              w_drop_d;
    logic [NOTE_W-1:0] w_note_d [NUM_VOICES];
    logic [VOL_W-1:0]  w_vol_d  [NUM_VOICES];
    logic [AGE_W-1:0]  w_age_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_gate_d;

    ps2_note_map u_note_map (
        .i_scancode (ps2_key[7:0]),
        .note       (w_map_note),
        .hit        (w_map_hit)
    );

    // Stage 0: a toggle edge is an event once the toggle copy has been primed after reset.
    always_comb begin
        w_evt        = r_armed & (ps2_key[10] ^ r_tog);
        w_s1_d.valid = w_evt & ~ps2_key[8] & w_map_hit;
        w_s1_d.press = ps2_key[9];
        w_s1_d.note  = w_map_note;
    end

    // Toggle copy, arming flag and stage-1 register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed <= 1'b0;
            r_tog   <= 1'b0;
            r_s1    <= '0;
        end else begin
            r_armed <= 1'b1;
            r_tog   <= ps2_key[10];
            r_s1    <= w_s1_d;
        end
    end

    // Free-running release prescaler; w_tick marks its terminal count.
    assign w_tick = (r_ps == PS_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ps <= '0;
        end else if (w_tick) begin
            r_ps <= '0;
        end else begin
            r_ps <= r_ps + 1'b1;
        end
    end

    // Stage 2 search: sounding voice with the same note, lowest free voice, oldest voice.
    always_comb begin
        w_same_hit = 1'b0;
        w_same_idx = '0;
        w_free_hit = 1'b0;
        w_free_idx = '0;
        w_old_idx  = '0;
        w_old_age  = r_age[0];
        // Descending scan so the lowest matching index wins.
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (r_vol[i] != '0 && r_note[i] == r_s1.note) begin
                w_same_hit = 1'b1;
                w_same_idx = IDX_W'(i);
            end
            if (r_vol[i] == '0) begin
                w_free_hit = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
        // Strict compare keeps ties on the lowest index.
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (r_age[i] > w_old_age) begin
                w_old_age = r_age[i];
                w_old_idx = IDX_W'(i);
            end
        end
    end

    // Stage 2 allocation decision for a note-on.
    always_comb begin
        w_src = SrcNone;
        if (r_s1.valid && r_s1.press) begin
            if (w_same_hit) begin
                w_src = SrcSame;
            end else if (w_free_hit) begin
                w_src = SrcFree;
            end else begin
`ifdef VOICE_STEAL_EN
                w_src = SrcSteal;
`else
                w_src = SrcDrop;
`endif
            end
        end

        w_tgt = '0;
        case (w_src)
            SrcSame:  w_tgt = w_same_idx;
            SrcFree:  w_tgt = w_free_idx;
            SrcSteal: w_tgt = w_old_idx;
            default:  w_tgt = '0;
        endcase

        w_place  = (w_src == SrcSame) || (w_src == SrcFree) || (w_src == SrcSteal);
        w_drop_d = (w_src == SrcDrop);
    end

    // Voice next state: release tick first, then the event overrides its target voice.
    always_comb begin
        w_gate_d = r_gate;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_note_d[i] = r_note[i];
            w_age_d[i]  = r_age[i];
            w_vol_d[i]  = r_vol[i];
            if (w_tick && !r_gate[i] && r_vol[i] != '0) begin
                w_vol_d[i] = r_vol[i] - 1'b1;
            end
        end

        if (w_place) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == w_tgt) begin
                    w_note_d[i] = r_s1.note;
                    w_gate_d[i] = 1'b1;
                    w_vol_d[i]  = VOL_MAX;
                    w_age_d[i]  = '0;
                end else if (r_vol[i] != '0 && r_age[i] != AGE_MAX) begin
                    w_age_d[i] = r_age[i] + 1'b1;
                end
            end
        end

        // Gated voices are never decremented, so clearing the gate leaves volume as-is this cycle.
        if (r_s1.valid && !r_s1.press) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (r_gate[i] && r_note[i] == r_s1.note) begin
                    w_gate_d[i] = 1'b0;
                end
            end
        end
    end

    // Voice state and drop pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= '0;
                r_vol[i]  <= '0;
                r_age[i]  <= '0;
            end
            r_gate <= '0;
            r_drop <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= w_note_d[i];
                r_vol[i]  <= w_vol_d[i];
                r_age[i]  <= w_age_d[i];
            end
            r_gate <= w_gate_d;
            r_drop <= w_drop_d;
        end
    end

    // Flatten per-voice state onto the output buses.
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
        assign voice_note[g*NOTE_W +: NOTE_W]  = r_note[g];
        assign voice_volume[g*VOL_W +: VOL_W]  = r_vol[g];
    end

    assign voice_gate = r_gate;
    assign event_drop = r_drop;

endmodule

// File: tb/tb_ps2_voice_alloc.sv
// Self-checking bench for ps2_voice_alloc: reference model + scoreboard, directed and random keys.
module tb_ps2_voice_alloc;

    localparam int NV = 4;
    localparam int RT = 8;

    logic                clk;
    logic                reset_n;
    logic [10:0]         ps2_key;
    logic [NV*7-1:0]     voice_note;
    logic [NV-1:0]       voice_gate;
    logic [NV*4-1:0]     voice_volume;
    logic                event_drop;

    ps2_voice_alloc #(
        .NUM_VOICES    (NV),
        .RELEASE_TICKS (RT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2_key      (ps2_key),
        .voice_note   (voice_note),
        .voice_gate   (voice_gate),
        .voice_volume (voice_volume),
        .event_drop   (event_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         due;
        bit         press;
        bit         ext;
        logic [7:0] code;
    } pend_t;

    typedef struct {
        logic [NV*7-1:0] note;
        logic [NV-1:0]   gate;
        logic [NV*4-1:0] vol;
        logic            drop;
        int              edge_n;
    } snap_t;

    typedef struct {
        string       name;
        logic [63:0] got;
        logic [63:0] exp;
    } chk_t;

    pend_t pend_q[$];
    snap_t exp_q[$];
    chk_t  chk_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what each voice is doing, counted in released clock edges.
    int m_note [NV];
    int m_gate [NV];
    int m_vol  [NV];
    int m_age  [NV];
    int m_edge;

    logic [7:0] codes [13] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A,
                               8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A, 8'h41};

    function automatic int key_note(input logic [7:0] c);
        case (c)
            8'h1A: return 48;
            8'h1B: return 49;
            8'h22: return 50;
            8'h23: return 51;
            8'h21: return 52;
            8'h2A: return 53;
            8'h34: return 54;
            8'h32: return 55;
            8'h33: return 56;
            8'h31: return 57;
            8'h3B: return 58;
            8'h3A: return 59;
            8'h41: return 60;
            default: return -1;
        endcase
    endfunction

    function automatic snap_t make_snap(input bit drop);
        snap_t s;
        for (int i = 0; i < NV; i++) begin
            s.note[i*7 +: 7] = 7'(m_note[i]);
            s.gate[i]        = m_gate[i][0];
            s.vol[i*4 +: 4]  = 4'(m_vol[i]);
        end
        s.drop   = drop;
        s.edge_n = m_edge;
        return s;
    endfunction

    // Reference model: advances one clock edge at a time and queues the expected outputs.
    initial begin : model
        pend_t pe;
        bit    tick;
        bit    drop;
        int    n;
        int    tgt;
        int    nvol [NV];
        m_edge = 0;
        for (int i = 0; i < NV; i++) begin
            m_note[i] = 0; m_gate[i] = 0; m_vol[i] = 0; m_age[i] = 0;
        end
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                for (int i = 0; i < NV; i++) begin
                    m_note[i] = 0; m_gate[i] = 0; m_vol[i] = 0; m_age[i] = 0;
                end
                pend_q.delete();
                m_edge = 0;
                exp_q.push_back(make_snap(1'b0));
            end else begin
                m_edge++;
                tick = (m_edge % RT == 0);
                drop = 1'b0;
                for (int i = 0; i < NV; i++) begin
                    nvol[i] = (tick && m_gate[i] == 0 && m_vol[i] > 0) ? m_vol[i] - 1 : m_vol[i];
                end
                while (pend_q.size() > 0 && pend_q[0].due <= m_edge) begin
                    pe = pend_q.pop_front();
                    n  = key_note(pe.code);
                    if (pe.due == m_edge && !pe.ext && n >= 0) begin
                        if (pe.press) begin
                            tgt = -1;
                            for (int i = 0; i < NV; i++)
                                if (tgt < 0 && m_vol[i] > 0 && m_note[i] == n) tgt = i;
                            for (int i = 0; i < NV; i++)
                                if (tgt < 0 && m_vol[i] == 0) tgt = i;
`ifdef VOICE_STEAL_EN
                            if (tgt < 0) begin
                                tgt = 0;
                                for (int i = 1; i < NV; i++)
                                    if (m_age[i] > m_age[tgt]) tgt = i;
                            end
`endif
                            if (tgt < 0) begin
                                drop = 1'b1;
                            end else begin
                                for (int j = 0; j < NV; j++)
                                    if (j != tgt && m_vol[j] > 0 && m_age[j] < NV - 1)
                                        m_age[j]++;
                                m_note[tgt] = n;
                                m_gate[tgt] = 1;
                                nvol[tgt]   = 15;
                                m_age[tgt]  = 0;
                            end
                        end else begin
                            for (int i = 0; i < NV; i++)
                                if (m_gate[i] == 1 && m_note[i] == n) m_gate[i] = 0;
                        end
                    end
                end
                for (int i = 0; i < NV; i++) m_vol[i] = nvol[i];
                exp_q.push_back(make_snap(drop));
            end
        end
    end

    // Monitor: compares DUT outputs against the queued expectations away from the active edge.
    initial begin : monitor
        snap_t e;
        chk_t  c;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_checks++;
                if (c.got !== c.exp) begin
                    n_errors++;
                    $display("FAIL %s: got %0h expected %0h", c.name, c.got, c.exp);
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({voice_note, voice_gate, voice_volume, event_drop} !==
                    {e.note, e.gate, e.vol, e.drop}) begin
                    n_errors++;
                    $display("FAIL snapshot edge %0d: got note=%h gate=%b vol=%h drop=%b expected note=%h gate=%b vol=%h drop=%b",
                             e.edge_n, voice_note, voice_gate, voice_volume, event_drop,
                             e.note, e.gate, e.vol, e.drop);
                end
            end
        end
    end

    task automatic spot(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_t c;
        c.name = name;
        c.got  = got;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One key event per call; the model expects its effect two edges after the toggle.
    task automatic send(input bit press, input bit ext, input logic [7:0] code);
        pend_t p;
        @(negedge clk);
        #1;
        ps2_key[10]  = ~ps2_key[10];
        ps2_key[9]   = press;
        ps2_key[8]   = ext;
        ps2_key[7:0] = code;
        p.due   = m_edge + 2;
        p.press = press;
        p.ext   = ext;
        p.code  = code;
        pend_q.push_back(p);
    endtask

    initial begin : stimulus
        int g;
        int r;
        reset_n = 1'b1;
        ps2_key = '0;
        #1 reset_n = 1'b0;
        idle(3);
        #1 reset_n = 1'b1;
        idle(2);
        spot("reset outputs", 64'({voice_note, voice_gate, voice_volume, event_drop}), 64'd0);

        // Single press / release / full decay
        send(1'b1, 1'b0, 8'h1A);
        idle(2);
        spot("press note0", 64'(voice_note[6:0]), 64'd48);
        spot("press gate0", 64'(voice_gate[0]), 64'd1);
        spot("press vol0", 64'(voice_volume[3:0]), 64'd15);
        send(1'b0, 1'b0, 8'h1A);
        idle(2);
        spot("release gate0", 64'(voice_gate[0]), 64'd0);
        idle(16 * RT);
        spot("decayed vol0", 64'(voice_volume[3:0]), 64'd0);

        // Retrigger during release reuses the same voice
        send(1'b1, 1'b0, 8'h1A);
        send(1'b0, 1'b0, 8'h1A);
        idle(2 + 3 * RT);
        spot("release 3 ticks vol0", 64'(voice_volume[3:0]), 64'd12);
        send(1'b1, 1'b0, 8'h1A);
        idle(2);
        spot("retrigger vol0", 64'(voice_volume[3:0]), 64'd15);
        spot("retrigger gate0", 64'(voice_gate[0]), 64'd1);
        spot("retrigger vol1", 64'(voice_volume[7:4]), 64'd0);
        send(1'b0, 1'b0, 8'h1A);
        idle(17 * RT);

        // Fill all voices back-to-back
        send(1'b1, 1'b0, 8'h1A);
        send(1'b1, 1'b0, 8'h22);
        send(1'b1, 1'b0, 8'h21);
        send(1'b1, 1'b0, 8'h2A);
        idle(2);
        spot("fill notes", 64'(voice_note), 64'({7'd53, 7'd52, 7'd50, 7'd48}));
        spot("fill gates", 64'(voice_gate), 64'hF);

        // Fifth press with every voice gated
        send(1'b1, 1'b0, 8'h32);
        idle(2);
`ifdef VOICE_STEAL_EN
        spot("steal notes", 64'(voice_note), 64'({7'd53, 7'd52, 7'd50, 7'd55}));
        spot("steal drop", 64'(event_drop), 64'd0);
`else
        spot("full notes", 64'(voice_note), 64'({7'd53, 7'd52, 7'd50, 7'd48}));
        spot("full drop", 64'(event_drop), 64'd1);
`endif

        // Extended and unmapped codes are ignored
        send(1'b1, 1'b1, 8'h75);
        send(1'b1, 1'b0, 8'h1C);
        idle(2);
        spot("ignored drop", 64'(event_drop), 64'd0);

        // Reset mid-operation, deasserting with the toggle high and a mapped press pending
        send(1'b0, 1'b0, 8'h22);
        send(1'b0, 1'b0, 8'h21);
        @(negedge clk);
        #1 reset_n = 1'b0;
        ps2_key = 11'h61A;
        #1;
        spot("async reset outputs", 64'({voice_note, voice_gate, voice_volume, event_drop}), 64'd0);
        idle(3);
        #1 reset_n = 1'b1;
        idle(4);
        spot("post reset outputs", 64'({voice_note, voice_gate, voice_volume, event_drop}), 64'd0);

        // Randomized key traffic
        for (int it = 0; it < 2500; it++) begin
            r = $urandom_range(0, 15);
            if (r < 12) begin
                send($urandom_range(0, 9) < 6, 1'b0, codes[$urandom_range(0, 5)]);
            end else if (r < 14) begin
                send($urandom_range(0, 1) == 1, 1'b0, codes[$urandom_range(0, 12)]);
            end else if (r == 14) begin
                send(1'b1, 1'b0, 8'h1C);
            end else begin
                send($urandom_range(0, 1) == 1, 1'b1, codes[$urandom_range(0, 12)]);
            end
            g = $urandom_range(0, 19);
            if (g >= 10 && g < 18) idle(g - 9);
            else if (g >= 18) idle(4 * RT);
        end

        idle(4);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_voice_alloc.md
PS2_VOICE_ALLOC -- requirements
Module: ps2_voice_alloc

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4: number of synth voices, range 2..8.
REQ-002 SHALL have parameter RELEASE_TICKS, default 9600: clk cycles per release volume step (10 ms at 0.96 MHz).
REQ-003 SHALL have port clk, input, 1: single clock, the audio clock domain.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ps2_key, input, 11:
- [10] toggles once per key event.
- [9] is 1 for pressed.
- [8] is 1 for extended.
- [7:0] is the set-2 scancode.
REQ-006 SHALL have port voice_note, output, NUM_VOICES*7: MIDI note per voice, voice i at [7i+6:7i].
REQ-007 SHALL have port voice_gate, output, NUM_VOICES: 1 while the key for that voice is held.
REQ-008 SHALL have port voice_volume, output, NUM_VOICES*4: per-voice level, 0..15.
REQ-009 SHALL have port event_drop, output, 1: one-cycle pulse when a note-on finds no voice.

Function
REQ-010 SHALL detect an event when ps2_key[10] differs from its registered copy; this is stage 0.
REQ-011 SHALL ignore any event with ps2_key[8]=1, and any scancode outside the key map.
REQ-012 SHALL use this key map, scancode to note:
- 1A=48, 1B=49, 22=50, 23=51, 21=52, 2A=53
- 34=54, 32=55, 33=56, 31=57, 3B=58, 3A=59, 41=60
REQ-013 SHALL register the decoded note in stage 1 and update the voice outputs in stage 2: latency 2 cycles from toggle to outputs.
REQ-014 SHALL apply a note-on to a target voice in this priority order:
- the voice already holding the same note (gated or releasing);
- otherwise the lowest-index free voice (volume 0);
- otherwise the steal rule (REQ-025/026).
REQ-015 SHALL, on note-on, set the target voice's note, gate=1, volume=15, age=0.
REQ-016 SHALL, on note-on, saturate-increment the age of every other voice with volume>0; ages saturate at NUM_VOICES-1.
REQ-017 SHALL, on note-off, clear the gate of every voice with a matching note and gate=1; volume is unchanged at that cycle.
REQ-018 SHALL ignore a note-off with no matching gated voice.
REQ-019 SHALL run a free-running prescaler of RELEASE_TICKS cycles.
REQ-020 SHALL, on each prescaler terminal count, decrement the volume of every voice with gate=0 and volume>0.
REQ-021 SHALL treat a voice reaching volume 0 as free; its note is retained.
REQ-022 SHALL, when a stage-2 event and a release tick coincide, let the event override the tick for the target voice; the tick still applies to all other voices.
REQ-023 SHALL accept back-to-back events on consecutive cycles without loss; the pipeline is fully pipelined, one event per cycle.
REQ-024 SHALL, when two pipelined events target the same note, make stage 2 see the result of the prior event.

Configuration
REQ-025 SHALL, with VOICE_STEAL_EN defined, steal on note-on when no voice is free:
- choose the voice with the greatest age, ties to the lowest index;
- apply REQ-015 to it;
- event_drop stays 0.
REQ-026 SHALL, without VOICE_STEAL_EN, drop such a note-on with no voice change and pulse event_drop for 1 cycle in stage 2.

Reset
REQ-027 SHALL, while reset_n=0, clear all registers asynchronously:
- voice_note=0, voice_gate=0, voice_volume=0, event_drop=0;
- ages, prescaler and pipeline valids to 0.
REQ-028 SHALL, on the first clk edge after reset_n deasserts, sample ps2_key[10] into the toggle register without generating an event.
REQ-029 SHALL discard any event in flight when reset asserts mid-pipeline.

Structure
REQ-030 SHALL place NOTE_W=7, VOL_W=4, VOL_MAX=15 and the key-map constants in the shared package synth_pkg.
REQ-031 SHALL place the scancode-to-note lookup in sub-module ps2_note_map, with outputs note[6:0] and hit.
REQ-032 SHALL keep the allocation, age and release logic in ps2_voice_alloc.

Verification
REQ-033 SHALL cover a single press: toggle with code 1A, pressed.
- 2 cycles later: voice0 note=48, gate=1, volume=15.
- Release with code 1A: gate=0.
- After 15*RELEASE_TICKS cycles: volume=0.
REQ-034 SHALL cover filling the voices: press 1A, 22, 21, 2A on consecutive cycles.
- Voices 0..3 get notes 48, 50, 52, 53.
- Ages end at 3, 2, 1, 0.
REQ-035 SHALL cover a fifth press, 32, with all 4 voices gated.
- With VOICE_STEAL_EN: voice0 takes note 55 and event_drop=0.
- Without VOICE_STEAL_EN: no voice change and one event_drop pulse.
REQ-036 SHALL cover a retrigger: press 1A, release, wait 3 release ticks (volume=12), press 1A again.
- The same voice is reused with volume=15 and gate=1.
REQ-037 SHALL cover ignored events: extended code E0 75 (ps2_key[8]=1) and unmapped code 1C.
- All outputs unchanged; event_drop=0.
REQ-038 SHALL cover reset mid-operation: assert reset_n=0 with 2 voices sounding, then deassert with ps2_key[10]=1.
- All outputs are 0.
- No spurious event on the first cycle after deassertion.
